// File: rtl/bk_sub16_pipe_pkg.sv
// Shared Brent-Kung prefix types and the black-cell operator.
// Latency: none (types and a pure function only).
// Backpressure: not applicable.
//
// Contents: BK_W (datapath width), bk_pg_t (propagate/generate pair),
// bk_dot(hi, lo) which combines a higher span with the span just below it.
package bk_pkg;

    localparam int BK_W = 16;

    typedef struct packed {
        logic p;
        logic g;
    } bk_pg_t;

    // Group propagate/generate of the concatenated span {hi, lo}.
    function automatic bk_pg_t bk_dot(input bk_pg_t hi, input bk_pg_t lo);
        return '{p: hi.p & lo.p, g: hi.g | (hi.p & lo.g)};
    endfunction

endpackage

// File: rtl/bk_prefix_cell.sv
// Single Brent-Kung black cell: merges two adjacent P/G spans.
// Latency: combinational.
// Backpressure: not applicable.
//
// Ports: hi (upper span P/G), lo (lower span P/G), grp (merged span P/G).
module bk_prefix_cell
    import bk_pkg::*;
(
    input  bk_pg_t hi,
    input  bk_pg_t lo,
    output bk_pg_t grp
);

    assign grp = bk_dot(hi, lo);

endmodule

// File: rtl/bk_sub16_pipe.sv
// Two-stage Brent-Kung subtractor a - b (= a + ~b + 1) with borrow/zero flags.
// Latency: 2 register stages (S1 = prefix levels 1-3, S2 = levels 4-6 + sum).
// Backpressure: valid/ready; a stalled stage holds, in_ready = S1 can advance.
//
// Ports: clk, rst (async active-high); in_valid/in_ready/a/b operand stream;
// out_valid/out_ready/diff/borrow/zero result stream.
// Optional: define BK_SUB_OVF_EN to add the registered signed-overflow port ovf.
module bk_sub16_pipe
    import bk_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [BK_W-1:0] a,
    input  logic [BK_W-1:0] b,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [BK_W-1:0] diff,
    output logic            borrow,
    output logic            zero
`ifdef BK_SUB_OVF_EN
    ,
    output logic            ovf
`endif
);

    // ---------------- handshake ----------------
    logic s1Vld, s2Vld;
    logic s1Adv, s2Adv;

    assign s2Adv     = ~s2Vld | out_ready;
    assign s1Adv     = ~s1Vld | s2Adv;
    assign in_ready  = s1Adv;
    assign out_valid = s2Vld;

    // ---------------- stage 1 tree (levels 1-3) ----------------
    bk_pg_t [BK_W-1:0] bitPg;
    bk_pg_t [7:0]      lvl1;   // pairs [2j+1:2j]
    bk_pg_t [3:0]      lvl2;   // nibbles [4j+3:4j]
    bk_pg_t [1:0]      lvl3;   // bytes [7:0], [15:8]

    always_comb begin
        for (int i = 0; i < BK_W; i++) begin
            bitPg[i].p = a[i] ^ ~b[i];
            bitPg[i].g = a[i] & ~b[i];
        end
        // The +1 of two's-complement subtraction is folded into bit 0 as a
        // carry-in of 1, so bit 0 generates whenever it would propagate.
        bitPg[0].g = (a[0] & ~b[0]) | (a[0] ^ ~b[0]);
    end

    for (genvar j = 0; j < 8; j++) begin : gLvl1
        bk_prefix_cell uCell (.hi(bitPg[2*j+1]), .lo(bitPg[2*j]), .grp(lvl1[j]));
    end
    for (genvar j = 0; j < 4; j++) begin : gLvl2
        bk_prefix_cell uCell (.hi(lvl1[2*j+1]), .lo(lvl1[2*j]), .grp(lvl2[j]));
    end
    for (genvar j = 0; j < 2; j++) begin : gLvl3
        bk_prefix_cell uCell (.hi(lvl2[2*j+1]), .lo(lvl2[2*j]), .grp(lvl3[j]));
    end

    bk_pg_t [BK_W-1:0] s1Bit;
    bk_pg_t [7:0]      s1L1;
    bk_pg_t [3:0]      s1L2;
    bk_pg_t [1:0]      s1L3;
`ifdef BK_SUB_OVF_EN
    logic s1SignA, s1SignB;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1Vld <= 1'b0;
            s1Bit <= '0;
            s1L1  <= '0;
            s1L2  <= '0;
            s1L3  <= '0;
`ifdef BK_SUB_OVF_EN
            s1SignA <= 1'b0;
            s1SignB <= 1'b0;
`endif
        end else if (s1Adv) begin
            s1Vld <= in_valid;
            if (in_valid) begin
                s1Bit <= bitPg;
                s1L1  <= lvl1;
                s1L2  <= lvl2;
                s1L3  <= lvl3;
`ifdef BK_SUB_OVF_EN
                s1SignA <= a[BK_W-1];
                s1SignB <= b[BK_W-1];
`endif
            end
        end
    end

    // ---------------- stage 2 tree (levels 4-6) ----------------
    // cin[i] is the P/G of span [i-1:0]; its .g is the carry into bit i.
    bk_pg_t cin [1:BK_W];

    assign cin[1] = s1Bit[0];
    assign cin[2] = s1L1[0];
    assign cin[4] = s1L2[0];
    assign cin[8] = s1L3[0];

    // level 4
    bk_prefix_cell uC16 (.hi(s1L3[1]), .lo(s1L3[0]), .grp(cin[16]));
    bk_prefix_cell uC12 (.hi(s1L2[2]), .lo(s1L3[0]), .grp(cin[12]));
    // level 5
    bk_prefix_cell uC6  (.hi(s1L1[2]), .lo(s1L2[0]), .grp(cin[6]));
    bk_prefix_cell uC10 (.hi(s1L1[4]), .lo(s1L3[0]), .grp(cin[10]));
    bk_prefix_cell uC14 (.hi(s1L1[6]), .lo(cin[12]), .grp(cin[14]));
    // level 6: odd bits extend the even carry below them by one bit
    for (genvar k = 3; k < BK_W; k = k + 2) begin : gOdd
        bk_prefix_cell uCell (.hi(s1Bit[k-1]), .lo(cin[k-1]), .grp(cin[k]));
    end

    logic [BK_W-1:0] carry;
    logic [BK_W-1:0] diffNext;

    always_comb begin
        carry[0] = 1'b1;
        for (int i = 1; i < BK_W; i++) begin
            carry[i] = cin[i].g;
        end
        for (int i = 0; i < BK_W; i++) begin
            diffNext[i] = s1Bit[i].p ^ carry[i];
        end
    end

    // Span propagates and a few registered groups are only needed for tree
    // shape; fold them here so they are visibly consumed.
    logic unusedBits;
    always_comb begin
        unusedBits = 1'b0;
        for (int i = 1; i <= BK_W; i++) begin
            unusedBits = unusedBits ^ cin[i].p;
        end
        for (int i = 1; i < BK_W; i = i + 2) begin
            unusedBits = unusedBits ^ s1Bit[i].g;
        end
        for (int j = 1; j < 8; j = j + 2) begin
            unusedBits = unusedBits ^ s1L1[j].p ^ s1L1[j].g;
        end
        unusedBits = unusedBits ^ (^{s1L2[1], s1L2[3]});
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s2Vld  <= 1'b0;
            diff   <= '0;
            borrow <= 1'b0;
            zero   <= 1'b0;
`ifdef BK_SUB_OVF_EN
            ovf    <= 1'b0;
`endif
        end else if (s2Adv) begin
            s2Vld <= s1Vld;
            if (s1Vld) begin
                diff   <= diffNext;
                borrow <= ~cin[BK_W].g;
                zero   <= ~|diffNext;
`ifdef BK_SUB_OVF_EN
                ovf    <= (s1SignA ^ s1SignB) & (diffNext[BK_W-1] ^ s1SignA);
`endif
            end
        end
    end

endmodule

// File: tb/tb_bk_sub16_pipe.sv
module tb_bk_sub16_pipe;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] a;
    logic [15:0] b;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] diff;
    logic        borrow;
    logic        zero;
`ifdef BK_SUB_OVF_EN
    logic        ovf;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    bk_sub16_pipe dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .a        (a),
        .b        (b),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .diff     (diff),
        .borrow   (borrow),
        .zero     (zero)
`ifdef BK_SUB_OVF_EN
        ,
        .ovf      (ovf)
`endif
    );

    typedef struct {
        logic [15:0] d;
        logic        bw;
        logic        z;
        logic        o;
    } res_t;

    // Reference: plain integer arithmetic on the operand values.
    function automatic res_t model(input logic [15:0] x, input logic [15:0] y);
        res_t r;
        int   sd;
        r.d  = 16'(x - y);
        r.bw = (x < y);
        r.z  = (x == y);
        sd   = int'($signed(x)) - int'($signed(y));
        r.o  = (sd > 32767) || (sd < -32768);
        return r;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0;
        tick(); tick();
        checks++;
        if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        checks++;
        if (diff !== 16'h0000) begin failures++; $display("FAIL reset_diff got=%h exp=0000", diff); end
        checks++;
        if (borrow !== 1'b0 || zero !== 1'b0) begin failures++; $display("FAIL reset_flags borrow=%b zero=%b exp=0/0", borrow, zero); end
`ifdef BK_SUB_OVF_EN
        checks++;
        if (ovf !== 1'b0) begin failures++; $display("FAIL reset_ovf got=%b exp=0", ovf); end
`endif
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    endtask

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] d;
        logic        bw;
        logic        z;
        logic        o;
    } vec_t;

    task automatic test_directed();
        vec_t v [8];
        v[0] = '{16'h0005, 16'h0003, 16'h0002, 1'b0, 1'b0, 1'b0};
        v[1] = '{16'h0003, 16'h0005, 16'hFFFE, 1'b1, 1'b0, 1'b0};
        v[2] = '{16'h0000, 16'hFFFF, 16'h0001, 1'b1, 1'b0, 1'b0};
        v[3] = '{16'h1234, 16'h1234, 16'h0000, 1'b0, 1'b1, 1'b0};
        v[4] = '{16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b0};
        v[5] = '{16'hFFFF, 16'h0001, 16'hFFFE, 1'b0, 1'b0, 1'b0};
        v[6] = '{16'h8000, 16'h0001, 16'h7FFF, 1'b0, 1'b0, 1'b1};
        v[7] = '{16'h7FFF, 16'hFFFF, 16'h8000, 1'b1, 1'b0, 1'b1};
        for (int i = 0; i < 8; i++) begin
            out_ready = 1'b1; in_valid = 1'b1; a = v[i].a; b = v[i].b;
            #1;
            checks++;
            if (in_ready !== 1'b1) begin failures++; $display("FAIL dir%0d_in_ready got=%b exp=1", i, in_ready); end
            tick();                      // operands accepted into S1
            in_valid = 1'b0;
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_early_valid got=%b exp=0", i, out_valid); end
            tick();                      // result reaches the output register
            checks++;
            if (out_valid !== 1'b1 || diff !== v[i].d || borrow !== v[i].bw || zero !== v[i].z) begin
                failures++;
                $display("FAIL dir%0d_result got v=%b d=%h bw=%b z=%b exp v=1 d=%h bw=%b z=%b",
                         i, out_valid, diff, borrow, zero, v[i].d, v[i].bw, v[i].z);
            end
`ifdef BK_SUB_OVF_EN
            checks++;
            if (ovf !== v[i].o) begin failures++; $display("FAIL dir%0d_ovf got=%b exp=%b", i, ovf, v[i].o); end
`endif
            tick();                      // consumed
            checks++;
            if (out_valid !== 1'b0) begin failures++; $display("FAIL dir%0d_drain got=%b exp=0", i, out_valid); end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] got [$];
        int k;
        bit acc;
        k = 0;
        for (int cyc = 0; cyc < 30; cyc++) begin
            out_ready = (cyc >= 2 && cyc <= 5) ? 1'b0 : 1'b1;
            in_valid  = (k < 4);
            a = 16'h0010;
            b = 16'(k);
            #1;
            if (cyc >= 2 && cyc <= 5) begin
                checks++;
                if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready cyc=%0d got=%b exp=0", cyc, in_ready); end
                checks++;
                if (out_valid !== 1'b1 || diff !== 16'h0010) begin
                    failures++;
                    $display("FAIL bp_stall_hold cyc=%0d got v=%b d=%h exp v=1 d=0010", cyc, out_valid, diff);
                end
            end
            if (out_valid && out_ready) got.push_back(diff);
            acc = in_valid && in_ready;
            tick();
            if (acc) k++;
        end
        in_valid = 1'b0;
        checks++;
        if (got.size() != 4) begin failures++; $display("FAIL bp_count got=%0d exp=4", got.size()); end
        for (int i = 0; i < 4 && i < got.size(); i++) begin
            checks++;
            if (got[i] !== 16'(16'h0010 - i)) begin
                failures++;
                $display("FAIL bp_order%0d got=%h exp=%h", i, got[i], 16'(16'h0010 - i));
            end
        end
    endtask

    task automatic test_reset_midstream();
        bit seen;
        out_ready = 1'b0; in_valid = 1'b1;
        a = 16'h0AAA; b = 16'h0001; #1; tick();
        a = 16'h0BBB; b = 16'h0002; #1; tick();
        in_valid = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_full got v=%b rdy=%b exp v=1 rdy=0", out_valid, in_ready);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || diff !== 16'h0000) begin
            failures++;
            $display("FAIL rstmid_async got v=%b d=%h exp v=0 d=0000", out_valid, diff);
        end
        tick();
        rst = 1'b0;
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rstmid_release got rdy=%b v=%b exp rdy=1 v=0", in_ready, out_valid);
        end
        out_ready = 1'b1; in_valid = 1'b1; a = 16'h0100; b = 16'h0001;
        tick();
        in_valid = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (out_valid) begin
                seen = 1'b1;
                checks++;
                if (diff !== 16'h00FF || borrow !== 1'b0) begin
                    failures++;
                    $display("FAIL rstmid_first got d=%h bw=%b exp d=00ff bw=0", diff, borrow);
                end
            end
            tick();
        end
        if (!seen) begin
            checks++; failures++;
            $display("FAIL rstmid_timeout got no out_valid exp one result");
        end
    endtask

    task automatic test_random();
        res_t        exp [$];
        res_t        e;
        bit          holdPrev;
        logic [15:0] prevD;
        logic        prevB, prevZ;
        holdPrev = 1'b0; prevD = '0; prevB = 1'b0; prevZ = 1'b0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            a = 16'($urandom);
            b = ($urandom_range(0, 7) == 0) ? a : 16'($urandom);
            #1;
            if (holdPrev) begin
                checks++;
                if (out_valid !== 1'b1 || diff !== prevD || borrow !== prevB || zero !== prevZ) begin
                    failures++;
                    $display("FAIL rnd_stable cyc=%0d got v=%b d=%h exp v=1 d=%h", cyc, out_valid, diff, prevD);
                end
            end
            if (out_valid && out_ready) begin
                checks++;
                if (exp.size() == 0) begin
                    failures++;
                    $display("FAIL rnd_spurious cyc=%0d got d=%h exp no result", cyc, diff);
                end else begin
                    e = exp.pop_front();
                    if (diff !== e.d || borrow !== e.bw || zero !== e.z) begin
                        failures++;
                        $display("FAIL rnd_result cyc=%0d got d=%h bw=%b z=%b exp d=%h bw=%b z=%b",
                                 cyc, diff, borrow, zero, e.d, e.bw, e.z);
                    end
`ifdef BK_SUB_OVF_EN
                    checks++;
                    if (ovf !== e.o) begin failures++; $display("FAIL rnd_ovf cyc=%0d got=%b exp=%b", cyc, ovf, e.o); end
`endif
                end
            end
            holdPrev = out_valid && !out_ready;
            prevD = diff; prevB = borrow; prevZ = zero;
            if (in_valid && in_ready) exp.push_back(model(a, b));
            tick();
        end
        in_valid = 1'b0; out_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            #1;
            if (out_valid && exp.size() > 0) begin
                e = exp.pop_front();
                checks++;
                if (diff !== e.d || borrow !== e.bw || zero !== e.z) begin
                    failures++;
                    $display("FAIL rnd_drain got d=%h bw=%b z=%b exp d=%h bw=%b z=%b",
                             diff, borrow, zero, e.d, e.bw, e.z);
                end
            end
            tick();
        end
        checks++;
        if (exp.size() != 0 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL rnd_leftover got pending=%0d v=%b exp pending=0 v=0", exp.size(), out_valid);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog got timeout exp completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_directed();
        test_backpressure();
        test_reset_midstream();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
